// File: rtl/riscv_core_mul_div_ctrl_if.sv
// riscv_core_mul_div_ctrl_if: execute-side request/writeback and mul/div unit signals of the M-extension controller
interface riscv_core_mul_div_ctrl_if #(
   parameter int XLEN = 64
);
   logic            i_md_ctrl_valid;
   logic [2:0]      i_md_ctrl_funct3;
   logic            i_md_ctrl_isword;
   logic [XLEN-1:0] i_md_ctrl_srcA;
   logic [XLEN-1:0] i_md_ctrl_srcB;
   logic [4:0]      i_md_ctrl_rd;
   logic            i_md_ctrl_flush;
   logic            o_md_ctrl_stall;
   logic            o_md_ctrl_wb_valid;
   logic [4:0]      o_md_ctrl_wb_rd;
   logic [XLEN-1:0] o_md_ctrl_wb_data;
   logic [XLEN-1:0] o_md_srcA;
   logic [XLEN-1:0] o_md_srcB;
   logic [3:0]      o_md_control;
   logic            o_md_isword;
   logic            o_md_en;
   logic            i_md_busy;
   logic            i_md_done;
   logic [XLEN-1:0] i_md_result;
   modport slave (
      input  i_md_ctrl_valid, i_md_ctrl_funct3, i_md_ctrl_isword, i_md_ctrl_srcA, i_md_ctrl_srcB,
             i_md_ctrl_rd, i_md_ctrl_flush, i_md_busy, i_md_done, i_md_result,
      output o_md_ctrl_stall, o_md_ctrl_wb_valid, o_md_ctrl_wb_rd, o_md_ctrl_wb_data,
             o_md_srcA, o_md_srcB, o_md_control, o_md_isword, o_md_en
   );
   modport master (
      output i_md_ctrl_valid, i_md_ctrl_funct3, i_md_ctrl_isword, i_md_ctrl_srcA, i_md_ctrl_srcB,
             i_md_ctrl_rd, i_md_ctrl_flush, i_md_busy, i_md_done, i_md_result,
      input  o_md_ctrl_stall, o_md_ctrl_wb_valid, o_md_ctrl_wb_rd, o_md_ctrl_wb_data,
             o_md_srcA, o_md_srcB, o_md_control, o_md_isword, o_md_en
   );
endinterface

// File: rtl/riscv_core_mul_div_ctrl.sv
// riscv_core_mul_div_ctrl: sequences M-extension ops through an external mul/div unit and writes back the result.
// Define MUL_DIV_CTRL_DIV_REUSE_EN to answer a repeat of the last completed divide from a cached result.
module riscv_core_mul_div_ctrl #(
   parameter int XLEN = 64
) (
   input logic i_md_ctrl_clk,
   input logic i_md_ctrl_rst,
   riscv_core_mul_div_ctrl_if.slave md
);
   typedef enum logic [2:0] {IDLE, EXEC, DIV_WAIT, DRAIN, WB} state_t;
   state_t state, state_nxt;
   logic [XLEN-1:0] src_a, src_b, res, hit_res;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic isword, drain_done, accept, hit, is_div, unused_busy;
   assign accept = state == IDLE && md.i_md_ctrl_valid && !md.i_md_ctrl_flush;
   assign is_div = funct3[2];
   assign unused_busy = md.i_md_busy;
`ifdef MUL_DIV_CTRL_DIV_REUSE_EN
   logic [XLEN-1:0] tag_a, tag_b;
   logic [2:0] tag_funct3;
   logic tag_isword, tag_valid;
   // the tag only ever holds a divide funct3, so a funct3 match implies a divide request
   assign hit = tag_valid && md.i_md_ctrl_funct3 == tag_funct3 && md.i_md_ctrl_isword == tag_isword &&
                md.i_md_ctrl_srcA == tag_a && md.i_md_ctrl_srcB == tag_b;
   always_ff @(posedge i_md_ctrl_clk)
      if (i_md_ctrl_rst) begin
         {tag_a, tag_b, tag_funct3, tag_isword, tag_valid} <= '0;
         hit_res <= '0;
      end else if (state == DIV_WAIT && md.i_md_done && !md.i_md_ctrl_flush) begin
         {tag_a, tag_b, tag_funct3, tag_isword, tag_valid} <= {src_a, src_b, funct3, isword, 1'b1};
         hit_res <= md.i_md_result;
      end
`else
   assign hit = 1'b0;
   assign hit_res = '0;
`endif
   always_ff @(posedge i_md_ctrl_clk)
      state <= i_md_ctrl_rst ? IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = accept ? (hit ? WB : EXEC) : IDLE;
         EXEC:     state_nxt = md.i_md_ctrl_flush ? (is_div ? DRAIN : IDLE) : (is_div ? DIV_WAIT : WB);
         DIV_WAIT: state_nxt = md.i_md_ctrl_flush ? DRAIN : (md.i_md_done ? WB : DIV_WAIT);
         DRAIN:    state_nxt = (md.i_md_done || drain_done) ? IDLE : DRAIN;
         WB:       state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_comb begin
      md.o_md_ctrl_stall = accept || state inside {EXEC, DIV_WAIT, DRAIN};
      md.o_md_en = state == EXEC;
      md.o_md_ctrl_wb_valid = state == WB;
   end
   assign md.o_md_ctrl_wb_rd = rd;
   assign md.o_md_ctrl_wb_data = res;
   assign md.o_md_srcA = src_a;
   assign md.o_md_srcB = src_b;
   assign md.o_md_control = {1'b0, funct3};
   assign md.o_md_isword = isword;
   always_ff @(posedge i_md_ctrl_clk)
      if (i_md_ctrl_rst) begin
         {src_a, src_b, funct3, isword, rd, res, drain_done} <= '0;
      end else begin
         if (accept)
            {src_a, src_b, funct3, isword, rd} <= {md.i_md_ctrl_srcA, md.i_md_ctrl_srcB,
                                                   md.i_md_ctrl_funct3, md.i_md_ctrl_isword, md.i_md_ctrl_rd};
         if (!md.i_md_ctrl_flush && ((state == EXEC && !is_div) || (state == DIV_WAIT && md.i_md_done)))
            res <= md.i_md_result;
         else if (accept && hit)
            res <= hit_res;
         // a done that coincides with the flush is already consumed, so DRAIN must not wait for another
         drain_done <= state == DIV_WAIT && md.i_md_ctrl_flush && md.i_md_done;
      end
endmodule

// File: tb/tb_riscv_core_mul_div_ctrl.sv
// tb_riscv_core_mul_div_ctrl: randomized scoreboard bench with a stub mul/div unit and an arithmetic reference model.
module tb_riscv_core_mul_div_ctrl;
   localparam int XLEN = 64;
`ifdef MUL_DIV_CTRL_DIV_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam int MIN32 = int'(32'h8000_0000);
   typedef struct packed {logic [4:0] rd; logic [63:0] data;} wb_t;
   logic clk = 1'b0, rst = 1'b1, noise = 1'b0;
   int vecs = 0, errs = 0, div_lat = 1, cnt = 0;
   logic [63:0] dres = '0;
   wb_t exp_q[$];
   wb_t e;
   logic [63:0] c_a = '0, c_b = '0;
   logic [2:0] c_f3 = '0;
   logic c_isw = 1'b0, c_valid = 1'b0;
   riscv_core_mul_div_ctrl_if #(.XLEN(XLEN)) md();
   riscv_core_mul_div_ctrl #(.XLEN(XLEN)) dut (.i_md_ctrl_clk(clk), .i_md_ctrl_rst(rst), .md(md));
   always #5 clk = ~clk;
   function automatic logic [63:0] ref_md(input logic [2:0] f3, input logic isw, input logic [63:0] a, input logic [63:0] b);
      logic signed [64:0] xa, xb;
      logic signed [129:0] p;
      longint sa, sb;
      int wa, wb;
      logic [31:0] r;
      if (isw) begin
         wa = int'(a[31:0]);
         wb = int'(b[31:0]);
         case (f3)
            3'd0: r = a[31:0] * b[31:0];
            3'd4: r = wb == 0 ? '1 : (wa == MIN32 && wb == -1) ? a[31:0] : 32'(wa / wb);
            3'd5: r = b[31:0] == 0 ? '1 : a[31:0] / b[31:0];
            3'd6: r = wb == 0 ? a[31:0] : (wa == MIN32 && wb == -1) ? '0 : 32'(wa % wb);
            default: r = b[31:0] == 0 ? a[31:0] : a[31:0] % b[31:0];
         endcase
         return {{32{r[31]}}, r};
      end
      sa = longint'(a);
      sb = longint'(b);
      xa = (f3 == 3'd1 || f3 == 3'd2) ? {a[63], a} : {1'b0, a};
      xb = f3 == 3'd1 ? {b[63], b} : {1'b0, b};
      p = xa * xb;
      case (f3)
         3'd0: return p[63:0];
         3'd1, 3'd2, 3'd3: return p[127:64];
         3'd4: return b == 0 ? '1 : (a == MIN64 && sb == -1) ? a : 64'(sa / sb);
         3'd5: return b == 0 ? '1 : a / b;
         3'd6: return b == 0 ? a : (a == MIN64 && sb == -1) ? '0 : 64'(sa % sb);
         default: return b == 0 ? a : a % b;
      endcase
   endfunction
   function automatic logic [63:0] rnd();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return 64'd1;
         2: return '1;
         3: return MIN64;
         4: return 64'($urandom_range(0, 200)) - 64'd100;
         5: return {32'($urandom), 32'h8000_0000};
         default: return {$urandom, $urandom};
      endcase
   endfunction
   function automatic logic [255:0] outs();
      return 256'({md.o_md_ctrl_stall, md.o_md_ctrl_wb_valid, md.o_md_ctrl_wb_rd, md.o_md_ctrl_wb_data,
                   md.o_md_srcA, md.o_md_srcB, md.o_md_control, md.o_md_isword, md.o_md_en});
   endfunction
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // stub unit: multiplies combinationally, divides with a programmable latency, and emits stray done pulses while idle
   always @(posedge clk) begin
      noise <= $urandom_range(0, 3) == 0;
      if (md.o_md_en && md.o_md_control[2]) begin
         cnt <= div_lat;
         dres <= ref_md(md.o_md_control[2:0], md.o_md_isword, md.o_md_srcA, md.o_md_srcB);
      end else if (cnt != 0) cnt <= cnt - 1;
   end
   assign md.i_md_busy = cnt != 0;
   assign md.i_md_done = cnt == 1 || (cnt == 0 && noise && !md.o_md_en);
   assign md.i_md_result = cnt == 1 ? dres : ref_md(md.o_md_control[2:0], md.o_md_isword, md.o_md_srcA, md.o_md_srcB);
   always @(negedge clk)
      if (md.o_md_ctrl_wb_valid) begin
         if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL wb_unexpected: got rd %0d data %0h, required no writeback", md.o_md_ctrl_wb_rd, md.o_md_ctrl_wb_data);
         end else begin
            e = exp_q.pop_front();
            chk("wb_rd_data", 256'({md.o_md_ctrl_wb_rd, md.o_md_ctrl_wb_data}), 256'(e));
         end
      end
   // fl: cycle offset from the accept cycle at which flush pulses (-1 = never, 0 = with the request)
   task automatic op(input logic [2:0] f3, input logic isw, input logic [63:0] a, input logic [63:0] b,
                     input logic [4:0] rd, input int lat, input int fl);
      bit hit;
      int wb_c, end_s, last;
      hit = REUSE && f3[2] && c_valid && {c_a, c_b, c_f3, c_isw} == {a, b, f3, isw};
      if (fl == 0) begin wb_c = -1; end_s = 0; end
      else if (hit) begin wb_c = 1; end_s = 1; end
      else if (!f3[2]) begin wb_c = fl == 1 ? -1 : 2; end_s = 2; end
      else begin
         wb_c = (fl >= 1 && fl <= lat + 1) ? -1 : lat + 2;
         end_s = fl == lat + 1 ? lat + 3 : lat + 2;
      end
      last = wb_c >= 0 ? wb_c + 1 : end_s;
      if (last < 2) last = 2;
      if (wb_c >= 0) exp_q.push_back(wb_t'{rd, ref_md(f3, isw, a, b)});
      if (wb_c >= 0 && f3[2] && !hit) begin
         {c_a, c_b, c_f3, c_isw} = {a, b, f3, isw};
         c_valid = 1'b1;
      end
      div_lat = lat;
      md.i_md_ctrl_valid = 1'b1;
      md.i_md_ctrl_funct3 = f3;
      md.i_md_ctrl_isword = isw;
      md.i_md_ctrl_srcA = a;
      md.i_md_ctrl_srcB = b;
      md.i_md_ctrl_rd = rd;
      md.i_md_ctrl_flush = fl == 0;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         chk("stall", 256'(md.o_md_ctrl_stall), 256'(c < end_s));
         chk("en", 256'(md.o_md_en), 256'(c == 1 && fl != 0 && !hit));
         chk("wb_valid", 256'(md.o_md_ctrl_wb_valid), 256'(c == wb_c));
         if (c == 1 && fl != 0 && !hit)
            chk("unit_drive", 256'({md.o_md_control, md.o_md_isword, md.o_md_srcA, md.o_md_srcB}), 256'({1'b0, f3, isw, a, b}));
         @(posedge clk);
         #1;
         md.i_md_ctrl_valid = 1'b0;
         md.i_md_ctrl_flush = c + 1 == fl;
         {md.i_md_ctrl_srcA, md.i_md_ctrl_srcB} = {$urandom, $urandom, $urandom, $urandom};
         md.i_md_ctrl_funct3 = 3'($urandom);
         md.i_md_ctrl_rd = 5'($urandom);
      end
      md.i_md_ctrl_flush = 1'b0;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [2:0] f3;
      logic isw;
      logic [63:0] a, b;
      int lat, fl;
      md.i_md_ctrl_valid = 1'b0;
      md.i_md_ctrl_funct3 = '0;
      md.i_md_ctrl_isword = 1'b0;
      md.i_md_ctrl_srcA = '0;
      md.i_md_ctrl_srcB = '0;
      md.i_md_ctrl_rd = '0;
      md.i_md_ctrl_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), '0);
      rst = 1'b0;
      op(3'd0, 1'b0, 64'd7, 64'd6, 5'd5, 1, -1);
      op(3'd5, 1'b0, 64'd100, 64'd7, 5'd6, 65, -1);
      op(3'd4, 1'b0, 64'd12345, 64'd17, 5'd7, 30, 12);
      op(3'd0, 1'b0, 64'd3, 64'd4, 5'd8, 1, 0);
      op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd3, 20, -1);
      op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd3, 20, -1);
      op(3'd6, 1'b0, 64'd999, 64'd10, 5'd9, 6, 5);
      op(3'd6, 1'b0, 64'd999, 64'd10, 5'd9, 6, -1);
      op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd4, 20, -1);
      op(3'd1, 1'b0, MIN64, 64'd3, 5'd10, 1, 1);
      op(3'd6, 1'b0, 64'd50, 64'd8, 5'd11, 8, 1);
      op(3'd7, 1'b0, 64'd77, 64'd9, 5'd12, 5, 6);
      op(3'd3, 1'b0, '1, '1, 5'd13, 1, 2);
      op(3'd4, 1'b1, 64'h0000_0001_8000_0000, '1, 5'd14, 4, -1);
      div_lat = 40;
      md.i_md_ctrl_valid = 1'b1;
      md.i_md_ctrl_funct3 = 3'd4;
      md.i_md_ctrl_srcA = 64'd1000;
      md.i_md_ctrl_srcB = 64'd3;
      md.i_md_ctrl_rd = 5'd9;
      @(posedge clk);
      #1 md.i_md_ctrl_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("stall_div_wait", 256'(md.o_md_ctrl_stall), 256'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      c_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_div_wait", outs(), '0);
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         chk("late_done_ignored", 256'({md.o_md_ctrl_wb_valid, md.o_md_ctrl_stall}), '0);
      end
      @(posedge clk);
      #1;
      op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd3, 20, -1);
      op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd3, 20, -1);
      for (int n = 0; n < 150; n++) begin
         if (c_valid && $urandom_range(0, 2) == 0) begin
            {a, b, f3, isw} = {c_a, c_b, c_f3, c_isw};
         end else begin
            f3 = 3'($urandom);
            isw = (f3 == 3'd0 || f3[2]) && $urandom_range(0, 1) == 1;
            a = rnd();
            b = rnd();
         end
         lat = int'($urandom_range(1, 8));
         fl = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 32'(lat + 3))) : -1;
         op(f3, isw, a, b, 5'($urandom), lat, fl);
      end
      @(negedge clk);
      chk("wb_pending", 256'(exp_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
